load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Multi-cycle load/store engine downstream of the CPU memory stage; sits between the core's memory-state control and the data memory.
- Takes one request per memory state: address, RV32I funct3 and store data.
- Performs byte-lane alignment, byte enables, sign/zero extension and misalignment/illegal-op detection.
- Runs a req/ack handshake with a variable-latency data memory and returns a done pulse plus load data to the writeback path.

Parameters:
- TIMEOUT, 16: max cycles mem_req may stay high without mem_ack before a timeout fault (range 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  request strobe from CPU memory stage; sampled only in IDLE.
- is_store  input  1  1 = store, 0 = load.
- funct3  input  3  RV32I width/sign code.
- addr  input  32  byte address.
- wdata  input  32  store data, low bits significant.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle completion pulse.
- rdata  output  32  extended load result.
- fault  output  2  00 none, 01 misaligned, 10 illegal funct3, 11 timeout; valid with done.
- mem_req  output  1  memory request, held until ack.
- mem_we  output  1  write enable.
- mem_be  output  4  byte enables.
- mem_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
- mem_wdata  output  32  lane-replicated store data.
- mem_rdata  input  32  memory read word, valid with mem_ack.
- mem_ack  input  1  memory completion; meaningful only while mem_req=1.

Behaviour:
- Reset is asynchronous active-low. While rst=0:
  - state=IDLE; all outputs 0, including rdata and fault.
  - mem_req drops immediately (reset mid-transaction abandons the request; memory must tolerate this).
- States: IDLE, REQ, DONE.
- IDLE:
  - start=1 captures is_store, funct3, addr and wdata into registers.
  - Legal and aligned request -> REQ.
  - Otherwise -> DONE with the fault code latched and no memory access (mem_req never rises).
  - start while busy is ignored.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else -> fault 10.
- Misaligned:
  - Halfword with addr[0]=1, or word with addr[1:0]!=0 -> fault 01.
  - Illegal funct3 takes priority over misaligned.
- REQ:
  - mem_req, mem_we, mem_be, mem_addr and mem_wdata are registered and stable for the whole REQ dwell.
  - Same-cycle combinational ack is allowed.
  - On mem_ack=1 -> DONE. For loads, mem_rdata is captured and extended into rdata on that edge.
  - An 8-bit wait counter clears on REQ entry and increments each REQ cycle without ack.
  - If ack is absent for TIMEOUT cycles: drop mem_req, -> DONE with fault 11; rdata unchanged.
- DONE: done=1 for exactly one cycle, busy=1, -> IDLE.
- Byte enables:
  - SB: 4'b0001<<addr[1:0].
  - SH: 4'b0011<<{addr[1],1'b0}.
  - SW: 4'b1111.
  - Loads drive the same pattern with mem_we=0.
- Store data:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Load extraction: lane selected by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- rdata holds its value until the next successful load; stores and faults never modify it.
- Latency (start accepted at edge T):
  - mem_req high in cycle T+1.
  - Ack in cycle T+k -> done in cycle T+k+1.
  - Zero-wait memory -> done at T+2.
  - Fault without access -> done at T+1.
- Back-to-back: start is accepted in the cycle after done at the earliest (state returns to IDLE).

Decomposition:
- Package rv_mem_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - Fault codes (FLT_NONE, FLT_MISALIGN, FLT_ILLEGAL, FLT_TIMEOUT).
  - State encoding.
- One combinational sub-module, lsu_lane_align:
  - Inputs: funct3, addr[1:0], wdata, mem_rdata.
  - Outputs: mem_be, replicated store data, extended load data.
- The FSM, counter and registers stay in load_store_unit.

Test Plan:
- Zero-wait LW: addr=0x100, memory returns 0xDEADBEEF with ack in the req cycle -> rdata=0xDEADBEEF, mem_be=1111, done at T+2, fault=00.
- LB/LBU on 0x103 with word 0x80FF7F01:
  - LB -> 0xFFFFFF80.
  - LBU -> 0x00000080.
  - LH at 0x102 -> 0xFFFF80FF.
- SB at 0x101 with wdata=0x000000AB -> mem_we=1, mem_be=0010, mem_wdata=0xABABABAB, mem_addr=0x100; rdata unchanged.
- Faults: SW at 0x102 -> done at T+1, fault=01, mem_req never high. funct3=011 load -> fault=10.
- Wait states and timeout:
  - ack after 5 cycles -> req held stable for 5 cycles, then done.
  - No ack with TIMEOUT=16 -> req drops after 16 cycles, fault=11.
- Async reset: rst low mid-REQ -> mem_req/busy fall without a clock edge; after release, a fresh LW completes normally.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared encodings for the RV32I load/store path: funct3 codes, fault codes, FSM states.
// Pure declarations and combinational helpers; no latency.
// No flow control of its own.
package rv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] FLT_NONE     = 2'b00;
    localparam logic [1:0] FLT_MISALIGN = 2'b01;
    localparam logic [1:0] FLT_ILLEGAL  = 2'b10;
    localparam logic [1:0] FLT_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_t;

    function automatic logic f3_legal(input logic is_st, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!is_st) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

    // f3[1:0] encodes the access size for every legal code
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] alo);
        logic bad;
        case (f3[1:0])
            2'b01:   bad = alo[0];
            2'b10:   bad = (alo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: byte enables, store-data replication and load extraction/extension.
// Purely combinational, zero latency.
// No backpressure; outputs follow inputs.
module lsu_lane_align
    import rv_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  mem_be,
    output logic [31:0] st_data,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = mem_rdata >> {addr_lo, 3'b000};
        mem_be  = 4'b1111;
        st_data = wdata;
        case (funct3[1:0])
            2'b00: begin
                mem_be  = 4'b0001 << addr_lo;
                st_data = {4{wdata[7:0]}};
            end
            2'b01: begin
                mem_be  = 4'b0011 << {addr_lo[1], 1'b0};
                st_data = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_data = shifted;
        case (funct3)
            F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   ld_data = {24'b0, shifted[7:0]};
            F3_HU:   ld_data = {16'b0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store engine between the memory stage and a req/ack data memory.
// Latency: done at T+k+1 for ack at T+k; faulted requests finish at T+1 with no access.
// Backpressure: start is only sampled in IDLE; mem_req holds until ack or TIMEOUT cycles.
module load_store_unit
    import rv_mem_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic [1:0]  fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    lsu_state_t  state_q, state_d;
    logic        st_q;
    logic [2:0]  f3_q;
    logic [1:0]  alo_q;
    logic [7:0]  wait_q;

    logic [2:0]  al_f3;
    logic [1:0]  al_alo;
    logic [3:0]  al_be;
    logic [31:0] al_st;
    logic [31:0] al_ld;
    logic [1:0]  req_fault;
    logic        timeout_hit;
    logic        is_idle;

    assign is_idle     = (state_q == ST_IDLE);
    assign busy        = !is_idle;
    assign done        = (state_q == ST_DONE);
    assign timeout_hit = (wait_q == 8'(TIMEOUT - 1));

    // In IDLE the aligner sees the live request so lanes can be registered on accept;
    // afterwards it sees the captured request so load extraction matches the access.
    assign al_f3  = is_idle ? funct3     : f3_q;
    assign al_alo = is_idle ? addr[1:0]  : alo_q;

    lsu_lane_align u_align (
        .funct3    (al_f3),
        .addr_lo   (al_alo),
        .wdata     (wdata),
        .mem_rdata (mem_rdata),
        .mem_be    (al_be),
        .st_data   (al_st),
        .ld_data   (al_ld)
    );

    always_comb begin
        req_fault = FLT_NONE;
        if (!f3_legal(is_store, funct3)) begin
            req_fault = FLT_ILLEGAL;
        end else if (f3_misaligned(funct3, addr[1:0])) begin
            req_fault = FLT_MISALIGN;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = (req_fault == FLT_NONE) ? ST_REQ : ST_DONE;
            ST_REQ:  if (mem_ack || timeout_hit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q      <= 1'b0;
            f3_q      <= 3'b0;
            alo_q     <= 2'b0;
            wait_q    <= 8'b0;
            rdata     <= 32'b0;
            fault     <= FLT_NONE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0;
            mem_addr  <= 32'b0;
            mem_wdata <= 32'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        st_q   <= is_store;
                        f3_q   <= funct3;
                        alo_q  <= addr[1:0];
                        wait_q <= 8'b0;
                        fault  <= req_fault;
                        if (req_fault == FLT_NONE) begin
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_be    <= al_be;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_wdata <= al_st;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_ack || timeout_hit) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_be    <= 4'b0;
                        mem_addr  <= 32'b0;
                        mem_wdata <= 32'b0;
                        if (mem_ack) begin
                            if (!st_q) rdata <= al_ld;
                        end else begin
                            fault <= FLT_TIMEOUT;
                        end
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
